// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } pll_sup_state_t;

  localparam int unsigned DEF_SYNC_STAGES         = 2;
  localparam int unsigned DEF_RST_PULSE_CYCLES    = 50;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 7;

  localparam int unsigned LOST_COUNT_W  = 8;
  localparam int unsigned RETRY_COUNT_W = 4;

  // Control outputs that are a pure function of the FSM state.
  typedef struct packed {
    logic pll_rst;
    logic sys_rst;
    logic fault;
  } pll_sup_ctl_t;

  // Output decode for a given state; applied to the next state so outputs
  // change on the same edge as the state register.
  function automatic pll_sup_ctl_t ctl_for(input pll_sup_state_t s);
    pll_sup_ctl_t c;
    c.pll_rst = (s == RESET_PLL) || (s == FAULT);
    c.sys_rst = (s != RUN);
    c.fault   = (s == FAULT);
    return c;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// N-stage synchronizer for a single asynchronous status bit.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the asynchronous input through the flop chain; cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL reset, qualifies lock, releases system reset, and latches a
// fault after repeated lock timeouts.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                     refclk,
  input  logic                     rst,
  input  logic                     locked,
  input  logic                     fault_clr,
  output logic                     pll_rst,
  output logic                     sys_rst,
  output logic                     fault,
  output logic [RETRY_COUNT_W-1:0] retry_count,
  output logic [LOST_COUNT_W-1:0]  lost_count
);

  localparam int unsigned CNT_MAX =
    max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_COUNT_W-1:0] RETRY_MAX = RETRY_COUNT_W'(MAX_RETRIES);

  pll_sup_state_t     state;
  logic [CNT_W-1:0]   cnt;
  pll_sup_ctl_t       ctl;
  logic               locked_s;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_locked_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Supervisor FSM with shared cycle counter and status counters; every
  // transition reloads the control outputs from the destination state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      ctl         <= ctl_for(RESET_PLL);
      retry_count <= '0;
      lost_count  <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state <= WAIT_LOCK;
            ctl   <= ctl_for(WAIT_LOCK);
            cnt   <= '0;
          end
        end

        WAIT_LOCK: begin
          // Lock takes priority over a coincident timeout.
          if (locked_s) begin
            state <= STABLE;
            ctl   <= ctl_for(STABLE);
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt <= '0;
            if (retry_count == RETRY_MAX) begin
              state <= FAULT;
              ctl   <= ctl_for(FAULT);
            end else begin
              retry_count <= retry_count + RETRY_COUNT_W'(1);
              state       <= RESET_PLL;
              ctl         <= ctl_for(RESET_PLL);
            end
          end
        end

        STABLE: begin
          // A drop on the final qualification cycle still aborts to WAIT_LOCK.
          if (!locked_s) begin
            state <= WAIT_LOCK;
            ctl   <= ctl_for(WAIT_LOCK);
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state       <= RUN;
            ctl         <= ctl_for(RUN);
            cnt         <= '0;
            retry_count <= '0;
          end
        end

        RUN: begin
          cnt <= '0;
          if (!locked_s) begin
            if (lost_count != '1) begin
              lost_count <= lost_count + LOST_COUNT_W'(1);
            end
            retry_count <= '0;
            state       <= RESET_PLL;
            ctl         <= ctl_for(RESET_PLL);
          end
        end

        FAULT: begin
          cnt <= '0;
          if (fault_clr) begin
            retry_count <= '0;
            state       <= RESET_PLL;
            ctl         <= ctl_for(RESET_PLL);
          end
        end

        default: begin
          state <= RESET_PLL;
          ctl   <= ctl_for(RESET_PLL);
          cnt   <= '0;
        end
      endcase
    end
  end

  assign pll_rst = ctl.pll_rst;
  assign sys_rst = ctl.sys_rst;
  assign fault   = ctl.fault;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized and directed bench for pll_lock_supervisor against a
// deadline-based reference model.
module tb_pll_lock_supervisor;

  localparam int unsigned SS = 2;
  localparam int unsigned RP = 4;
  localparam int unsigned LT = 20;
  localparam int unsigned LS = 8;
  localparam int unsigned MR = 2;
  localparam logic [14:0] RST_VEC = 15'b110_0000_00000000;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked;
  logic       fault_clr;
  logic       pll_rst;
  logic       sys_rst;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lost_count;

  pll_lock_supervisor #(
    .SYNC_STAGES         (SS),
    .RST_PULSE_CYCLES    (RP),
    .LOCK_TIMEOUT_CYCLES (LT),
    .LOCK_STABLE_CYCLES  (LS),
    .MAX_RETRIES         (MR)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .locked      (locked),
    .fault_clr   (fault_clr),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .fault       (fault),
    .retry_count (retry_count),
    .lost_count  (lost_count)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: phases with absolute deadlines, lock seen SS samples late.
  typedef enum {M_PULSE, M_WAIT, M_QUAL, M_RUN, M_FAULT} mphase_t;
  mphase_t mph;
  int      e_cnt;
  int      deadline;
  int      m_retries;
  int      m_losses;
  logic    lk_q[$];

  function automatic void model_reset();
    mph       = M_PULSE;
    e_cnt     = 0;
    deadline  = RP;
    m_retries = 0;
    m_losses  = 0;
    lk_q.delete();
    for (int i = 0; i < int'(SS); i++) lk_q.push_back(1'b0);
  endfunction

  function automatic void model_edge(input logic lk, input logic fc);
    logic ls;
    e_cnt++;
    ls = lk_q.pop_front();
    lk_q.push_back(lk);
    case (mph)
      M_PULSE: if (e_cnt == deadline) begin mph = M_WAIT; deadline = e_cnt + LT; end
      M_WAIT: begin
        if (ls) begin
          mph = M_QUAL; deadline = e_cnt + LS;
        end else if (e_cnt == deadline) begin
          if (m_retries == int'(MR)) mph = M_FAULT;
          else begin m_retries++; mph = M_PULSE; deadline = e_cnt + RP; end
        end
      end
      M_QUAL: begin
        if (!ls) begin mph = M_WAIT; deadline = e_cnt + LT; end
        else if (e_cnt == deadline) begin mph = M_RUN; m_retries = 0; end
      end
      M_RUN: if (!ls) begin
        if (m_losses < 255) m_losses++;
        m_retries = 0; mph = M_PULSE; deadline = e_cnt + RP;
      end
      M_FAULT: if (fc) begin m_retries = 0; mph = M_PULSE; deadline = e_cnt + RP; end
      default: ;
    endcase
  endfunction

  function automatic logic [14:0] model_vec();
    return {mph == M_PULSE || mph == M_FAULT, mph != M_RUN, mph == M_FAULT,
            4'(m_retries), 8'(m_losses)};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {pll_rst, sys_rst, fault, retry_count, lost_count};
  endfunction

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare every output shortly after.
  task automatic tick();
    logic lk, fc, r;
    lk = locked; fc = fault_clr; r = rst;
    @(posedge refclk);
    if (r) model_reset();
    else   model_edge(lk, fc);
    #1;
    check("outs", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic wait_run(input string tag, input int limit);
    int n = 0;
    while (sys_rst && n < limit) begin tick(); n++; end
    check(tag, 32'(sys_rst), 32'(0));
  endtask

  task automatic measure_release(input string tag);
    int n = 0;
    forever begin
      tick();
      if (!sys_rst || n >= 40) break;
      n++;
    end
    check(tag, 32'(n), 32'(SS + LS));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    rst = 1'b1; locked = 1'b0; fault_clr = 1'b0;
    model_reset();
    #1;
    check("reset_vals", 32'(dut_vec()), 32'(RST_VEC));
    tick(); tick();
    rst = 1'b0;

    // Normal lock, locked sampled high at edge 10.
    repeat (9) tick();
    locked = 1'b1;
    measure_release("lock_latency");
    check("lock_retry", 32'(retry_count), 32'(0));

    // Loss in RUN, repeated until lost_count saturates.
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      tick();
      if (i == 0) check("loss_k0", 32'(sys_rst), 32'(0));
      tick();
      if (i == 0) check("loss_k1", 32'(sys_rst), 32'(0));
      tick();
      if (i == 0) begin
        check("loss_k2", 32'({sys_rst, pll_rst}), 32'(2'b11));
        n = 1;
        forever begin
          tick();
          if (!pll_rst || n >= 20) break;
          n++;
        end
        check("loss_pulse", 32'(n), 32'(RP));
        check("loss_cnt1", 32'(lost_count), 32'(1));
      end
      repeat ($urandom_range(0, 4)) tick();
      locked = 1'b1;
      wait_run("relock", 60);
    end
    check("lost_sat", 32'(lost_count), 32'(255));

    // Glitch during qualification.
    locked = 1'b0;
    do_reset();
    check("lost_clr", 32'(lost_count), 32'(0));
    repeat (9) tick();
    locked = 1'b1;
    repeat (5) tick();
    locked = 1'b0;
    repeat (3) tick();
    check("glitch_sys", 32'(sys_rst), 32'(1));
    locked = 1'b1;
    measure_release("glitch_latency");

    // No lock: fault after three attempts.
    locked = 1'b0;
    do_reset();
    repeat (71) tick();
    check("fault_early", 32'(fault), 32'(0));
    tick();
    check("fault_at72", 32'(fault), 32'(1));
    check("fault_retry", 32'(retry_count), 32'(MR));
    repeat (10) tick();
    check("fault_hold", 32'({pll_rst, sys_rst, fault}), 32'(3'b111));
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("fclr_fault", 32'({pll_rst, fault, retry_count}), 32'({1'b1, 1'b0, 4'd0}));
    locked = 1'b1;
    wait_run("run_after_clr", 60);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("fclr_in_run", 32'({pll_rst, sys_rst, fault, retry_count}), 32'(0));

    // Randomized lock behaviour, fault clears and occasional resets.
    n = 0;
    while (n < 4000) begin
      locked = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 110))
                                        : int'($urandom_range(1, 25));
      for (int j = 0; j < len; j++) begin
        fault_clr = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 599) == 0) rst = 1'b1;
        tick();
        rst = 1'b0; fault_clr = 1'b0;
        n++;
      end
    end

    // Reset asserted between edges in WAIT_LOCK.
    locked = 1'b0;
    do_reset();
    repeat (5) tick();
    check("mid_wait", 32'({pll_rst, sys_rst}), 32'(2'b01));
    #3 rst = 1'b1;
    #1;
    check("mid_rst", 32'(dut_vec()), 32'(RST_VEC));
    model_reset();
    tick();
    rst = 1'b0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
